// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, with start/busy/done handshake.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiply (divide stays iterative).
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             cancel,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, step, prod;
  logic [WIDTH-1:0] dvs_q, dvs_d, hi_q, hi_d, lo_q, lo_d;
  logic div_q, div_d, neg_a_q, neg_a_d, neg_b_q, neg_b_d, dz_q, dz_d, divzero_q, divzero_d;
  logic accept, last, a_neg, b_neg, ge, carry;
  logic [WIDTH-1:0] a_mag, b_mag, sum, diff, quo, rem;
  logic [WIDTH:0] shl;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast, fast_s;
`endif
  always_comb begin
    a_neg = ~op[0] & srca[WIDTH-1];
    b_neg = ~op[0] & srcb[WIDTH-1];
    a_mag = a_neg ? -srca : srca;
    b_mag = b_neg ? -srcb : srcb;
    accept = start & ~cancel & (state_q != RUN);
    last = (state_q == RUN) && (cnt_q == CNTW'(WIDTH - 1));
    // multiply: shift-add with carry into the top; divide: restoring, remainder in the upper half
    {carry, sum} = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, dvs_q};
    shl = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    ge = shl >= {1'b0, dvs_q};
    diff = shl[WIDTH-1:0] - dvs_q;
    step = div_q ? {ge ? diff : shl[WIDTH-1:0], acc_q[WIDTH-2:0], ge}
         : acc_q[0] ? {carry, sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
    prod = (neg_a_q ^ neg_b_q) ? -step : step;
    quo = dz_q ? '1 : (neg_a_q ^ neg_b_q) ? -step[WIDTH-1:0] : step[WIDTH-1:0];
    rem = neg_a_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    dvs_d = dvs_q;
    div_d = div_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    dz_d = dz_q;
    divzero_d = 1'b0;
    hi_d = (state_q != RUN && wr_hi) ? wdata : hi_q;
    lo_d = (state_q != RUN && wr_lo) ? wdata : lo_q;
    if (state_q == DONE) state_d = IDLE;
    if (state_q == RUN) begin
      if (cancel) state_d = IDLE;
      else begin
        acc_d = step;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          hi_d = div_q ? rem : prod[2*WIDTH-1:WIDTH];
          lo_d = div_q ? quo : prod[WIDTH-1:0];
          divzero_d = div_q & dz_q;
        end
      end
    end
    if (accept) begin
      state_d = RUN;
      cnt_d = '0;
      div_d = op[1];
      neg_a_d = a_neg;
      neg_b_d = b_neg;
      dz_d = op[1] && (srcb == '0);
      dvs_d = op[1] ? b_mag : a_mag;
      acc_d = {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
    end
`ifdef MULDIV_FAST_MUL_EN
    fast = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
    fast_s = (a_neg ^ b_neg) ? -fast : fast;
    if (accept && !op[1]) begin
      state_d = DONE;
      hi_d = fast_s[2*WIDTH-1:WIDTH];
      lo_d = fast_s[WIDTH-1:0];
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      dvs_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      div_q <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      dz_q <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      dvs_q <= dvs_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      div_q <= div_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      dz_q <= dz_d;
      divzero_q <= divzero_d;
    end
  end
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign divzero = divzero_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule
